// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcodes, flag bit positions and FSM encoding for alu_seq
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

   localparam int OP_W  = 4;
   localparam int FLG_W = 4;

   localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
   localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
   localparam logic [OP_W-1:0] OP_PASS = 4'd2;
   localparam logic [OP_W-1:0] OP_INC  = 4'd3;
   localparam logic [OP_W-1:0] OP_DEC2 = 4'd4;
   localparam logic [OP_W-1:0] OP_DEC  = 4'd5;
   localparam logic [OP_W-1:0] OP_AND  = 4'd6;
   localparam logic [OP_W-1:0] OP_OR   = 4'd7;
   localparam logic [OP_W-1:0] OP_XOR  = 4'd8;
   localparam logic [OP_W-1:0] OP_SHL  = 4'd9;
   localparam logic [OP_W-1:0] OP_SHR  = 4'd10;
   localparam logic [OP_W-1:0] OP_MUL  = 4'd11;

   localparam int FLG_Z = 3;
   localparam int FLG_N = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_seq_if.sv
// ============================================================================
//  Module      : alu_seq_if
//  Description : START/DONE request bus between the controller and alu_seq
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_seq_if #(
   parameter int WIDTH = 8
) ();
   import alu_pkg::*;

   logic              start;
   logic [OP_W-1:0]   op;
   logic [WIDTH-1:0]  in1;
   logic [WIDTH-1:0]  in2;
   logic              busy;
   logic              done;
   logic [WIDTH-1:0]  out;
   logic [FLG_W-1:0]  flags;

   modport master (
      output start, op, in1, in2,
      input  busy, done, out, flags
   );

   modport slave (
      input  start, op, in1, in2,
      output busy, done, out, flags
   );

endinterface

`default_nettype wire

// File: rtl/alu_mul_seq.sv
// ============================================================================
//  Module      : alu_mul_seq
//  Description : Iterative shift-add unsigned multiplier, one bit per clock
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_mul_seq #(
   parameter int WIDTH = 8
) (
   input  wire logic               clk,
   input  wire logic               rst,
   input  wire logic               i_start,
   input  wire logic [WIDTH-1:0]   i_a,
   input  wire logic [WIDTH-1:0]   i_b,
   output logic                    o_busy,
   output logic                    o_done,
   output logic [2*WIDTH-1:0]      o_product
);

   localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
   localparam logic [c_cnt_w-1:0] c_cnt_init = c_cnt_w'(WIDTH);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   logic                r_busy;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [2*WIDTH-1:0]  r_acc;
   logic [2*WIDTH-1:0]  r_mcand;
   logic [WIDTH-1:0]    r_mplier;
   logic [2*WIDTH-1:0]  w_acc_next;

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_busy   <= 1'b0;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
      end else if (i_start && !r_busy) begin
         r_busy   <= 1'b1;
         r_cnt    <= c_cnt_init;
         r_acc    <= '0;
         r_mcand  <= {{WIDTH{1'b0}}, i_a};
         r_mplier <= i_b;
      end else if (r_busy) begin
         r_acc    <= w_acc_next;
         r_mcand  <= {r_mcand[2*WIDTH-2:0], 1'b0};
         r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
         r_cnt    <= r_cnt - c_cnt_one;
         if (r_cnt == c_cnt_one) begin
            r_busy <= 1'b0;
         end
      end
   end

   // The final partial product is handed out combinationally so the owner can
   // register it on the same edge that retires the last iteration.
   assign o_busy    = r_busy;
   assign o_done    = r_busy && (r_cnt == c_cnt_one);
   assign o_product = w_acc_next;

endmodule

`default_nettype wire

// File: rtl/alu_seq.sv
// ============================================================================
//  Module      : alu_seq
//  Description : Registered ALU with Z/N/C/V flags and iterative multiply
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  wire logic   clk,
   input  wire logic   rst,
   alu_seq_if.slave    bus
);

   localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] c_two = {{(WIDTH-2){1'b0}}, 2'b10};

   state_t              r_state;
   state_t              w_state_next;
   logic                w_accept_single;
   logic                w_mul_start;
   logic                w_mul_busy;
   logic                w_mul_done;
   logic [2*WIDTH-1:0]  w_prod;

   logic [WIDTH-1:0]    w_opb;
   logic                w_sub;
   logic                w_arith;
   logic [WIDTH:0]      w_wide;
   logic [WIDTH-1:0]    w_res;
   logic                w_c;
   logic                w_v;
   logic [WIDTH-1:0]    w_fin_res;
   logic [FLG_W-1:0]    w_fin_flags;

   logic [WIDTH-1:0]    r_out;
   logic [FLG_W-1:0]    r_flags;
   logic                r_done;

   alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
      .clk       (clk),
      .rst       (rst),
      .i_start   (w_mul_start),
      .i_a       (bus.in1),
      .i_b       (bus.in2),
      .o_busy    (w_mul_busy),
      .o_done    (w_mul_done),
      .o_product (w_prod)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next    = r_state;
      w_accept_single = 1'b0;
      w_mul_start     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.start && !w_mul_busy) begin
               if (bus.op == OP_MUL) begin
                  w_mul_start  = 1'b1;
                  w_state_next = ST_MUL;
               end else begin
                  w_accept_single = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (w_mul_done) begin
               w_state_next = ST_IDLE;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Single-cycle datapath; arithmetic ops share one WIDTH+1 adder/subtractor.
   always_comb begin
      w_opb   = bus.in2;
      w_sub   = 1'b0;
      w_arith = 1'b0;
      w_res   = '0;
      w_c     = 1'b0;
      w_v     = 1'b0;
      case (bus.op)
         OP_ADD:  w_arith = 1'b1;
         OP_SUB:  begin w_arith = 1'b1; w_sub = 1'b1; end
         OP_INC:  begin w_arith = 1'b1; w_opb = c_one; end
         OP_DEC2: begin w_arith = 1'b1; w_sub = 1'b1; w_opb = c_two; end
         OP_DEC:  begin w_arith = 1'b1; w_sub = 1'b1; w_opb = c_one; end
         OP_PASS: w_res = bus.in1;
         OP_AND:  w_res = bus.in1 & bus.in2;
         OP_OR:   w_res = bus.in1 | bus.in2;
         OP_XOR:  w_res = bus.in1 ^ bus.in2;
         OP_SHL:  begin w_res = {bus.in1[WIDTH-2:0], 1'b0}; w_c = bus.in1[WIDTH-1]; end
         OP_SHR:  begin w_res = {1'b0, bus.in1[WIDTH-1:1]}; w_c = bus.in1[0]; end
         default: w_res = '0;
      endcase
      w_wide = w_sub ? ({1'b0, bus.in1} - {1'b0, w_opb})
                     : ({1'b0, bus.in1} + {1'b0, w_opb});
      if (w_arith) begin
         w_res = w_wide[WIDTH-1:0];
         w_c   = w_wide[WIDTH];
         w_v   = ((bus.in1[WIDTH-1] ^ w_opb[WIDTH-1]) == w_sub) &&
                 (w_wide[WIDTH-1] != bus.in1[WIDTH-1]);
      end
   end

   always_comb begin
      w_fin_res          = w_mul_done ? w_prod[WIDTH-1:0] : w_res;
      w_fin_flags        = '0;
      w_fin_flags[FLG_Z] = (w_fin_res == '0);
      w_fin_flags[FLG_N] = w_fin_res[WIDTH-1];
      w_fin_flags[FLG_C] = w_mul_done ? (|w_prod[2*WIDTH-1:WIDTH]) : w_c;
      w_fin_flags[FLG_V] = w_mul_done ? 1'b0 : w_v;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out   <= '0;
         r_flags <= '0;
         r_done  <= 1'b0;
      end else begin
         r_done <= w_accept_single || w_mul_done;
         if (w_accept_single || w_mul_done) begin
            r_out   <= w_fin_res;
            r_flags <= w_fin_flags;
         end
      end
   end

   assign bus.busy  = (r_state == ST_MUL);
   assign bus.done  = r_done;
   assign bus.out   = r_out;
   assign bus.flags = r_flags;

endmodule

`default_nettype wire

// File: tb/tb_alu_seq.sv
// ============================================================================
//  Module      : tb_alu_seq
//  Description : Directed self-checking bench for alu_seq at WIDTH=8 and 16
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_seq;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.WIDTH(8))  b8 ();
   alu_seq_if #(.WIDTH(16)) b16 ();

   alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
   alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      b8.start = 1'b0;  b8.op = OP_ADD;  b8.in1 = '0;  b8.in2 = '0;
      b16.start = 1'b0; b16.op = OP_ADD; b16.in1 = '0; b16.in2 = '0;
      tick(); tick();
      checks++; if (b8.out !== 8'h00) begin errors++; $display("FAIL reset_out: got %h want 00", b8.out); end
      checks++; if (b8.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", b8.flags); end
      checks++; if (b8.busy !== 1'b0 || b8.done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b want 00", b8.busy, b8.done); end
      checks++; if (b16.out !== 16'h0000 || b16.done !== 1'b0) begin errors++; $display("FAIL reset_w16: got out=%h done=%b want 0000/0", b16.out, b16.done); end
      rst = 1'b0;
      tick();
   endtask

   task automatic test_add_sub();
      b8.start = 1'b1; b8.op = OP_ADD; b8.in1 = 8'hFF; b8.in2 = 8'h01;
      tick();
      b8.start = 1'b0;
      checks++; if (b8.done !== 1'b1) begin errors++; $display("FAIL add_done_lat1: got %b want 1", b8.done); end
      checks++; if (b8.out !== 8'h00 || b8.flags !== 4'b1010) begin errors++; $display("FAIL add_ff_01: got %h/%b want 00/1010", b8.out, b8.flags); end
      tick();
      checks++; if (b8.done !== 1'b0) begin errors++; $display("FAIL add_done_pulse: got %b want 0", b8.done); end
      b8.start = 1'b1; b8.op = OP_SUB; b8.in1 = 8'h80; b8.in2 = 8'h01;
      tick();
      b8.op = OP_DEC2; b8.in1 = 8'h01; b8.in2 = 8'h77;
      checks++; if (b8.out !== 8'h7F || b8.flags !== 4'b0001) begin errors++; $display("FAIL sub_80_01: got %h/%b want 7f/0001", b8.out, b8.flags); end
      tick();
      b8.start = 1'b0;
      checks++; if (b8.done !== 1'b1 || b8.out !== 8'hFF || b8.flags !== 4'b0110) begin errors++; $display("FAIL dec2_01_b2b: got done=%b %h/%b want 1 ff/0110", b8.done, b8.out, b8.flags); end
      tick();
   endtask

   task automatic test_ops();
      logic [3:0] ops [9];
      logic [7:0] as  [9];
      logic [7:0] bs  [9];
      logic [7:0] eo  [9];
      logic [3:0] ef  [9];
      ops[0] = OP_PASS; as[0] = 8'h85; bs[0] = 8'h00; eo[0] = 8'h85; ef[0] = 4'b0100;
      ops[1] = OP_INC;  as[1] = 8'h7F; bs[1] = 8'h00; eo[1] = 8'h80; ef[1] = 4'b0101;
      ops[2] = OP_DEC;  as[2] = 8'h00; bs[2] = 8'h00; eo[2] = 8'hFF; ef[2] = 4'b0110;
      ops[3] = OP_AND;  as[3] = 8'hF0; bs[3] = 8'h3C; eo[3] = 8'h30; ef[3] = 4'b0000;
      ops[4] = OP_OR;   as[4] = 8'h0F; bs[4] = 8'hF0; eo[4] = 8'hFF; ef[4] = 4'b0100;
      ops[5] = OP_XOR;  as[5] = 8'hAA; bs[5] = 8'hAA; eo[5] = 8'h00; ef[5] = 4'b1000;
      ops[6] = OP_SHL;  as[6] = 8'h81; bs[6] = 8'h00; eo[6] = 8'h02; ef[6] = 4'b0010;
      ops[7] = OP_SHR;  as[7] = 8'h81; bs[7] = 8'h00; eo[7] = 8'h40; ef[7] = 4'b0010;
      ops[8] = 4'hC;    as[8] = 8'h05; bs[8] = 8'h09; eo[8] = 8'h00; ef[8] = 4'b1000;
      for (int i = 0; i < 9; i++) begin
         b8.start = 1'b1; b8.op = ops[i]; b8.in1 = as[i]; b8.in2 = bs[i];
         tick();
         b8.start = 1'b0;
         checks++;
         if (b8.done !== 1'b1 || b8.out !== eo[i] || b8.flags !== ef[i]) begin
            errors++;
            $display("FAIL op%0d_vec%0d: got done=%b %h/%b want 1 %h/%b", ops[i], i, b8.done, b8.out, b8.flags, eo[i], ef[i]);
         end
         tick();
      end
   endtask

   task automatic test_mul_ignore();
      int lat;
      int nbusy;
      b8.start = 1'b1; b8.op = OP_MUL; b8.in1 = 8'd15; b8.in2 = 8'd17;
      tick();
      b8.start = 1'b0; b8.in1 = 8'hAA; b8.in2 = 8'h55;
      lat = 1; nbusy = 0;
      while (b8.done !== 1'b1 && lat < 40) begin
         if (b8.busy === 1'b1) nbusy++;
         if (lat == 3) begin
            b8.start = 1'b1; b8.op = OP_ADD; b8.in1 = 8'h01; b8.in2 = 8'h01;
         end else begin
            b8.start = 1'b0;
         end
         tick();
         lat++;
      end
      b8.start = 1'b0;
      checks++; if (lat != 9) begin errors++; $display("FAIL mul_latency: got %0d want 9", lat); end
      checks++; if (nbusy != 8 || b8.busy !== 1'b0) begin errors++; $display("FAIL mul_busy: got %0d cycles busy_at_done=%b want 8/0", nbusy, b8.busy); end
      checks++; if (b8.out !== 8'hFF || b8.flags !== 4'b0100) begin errors++; $display("FAIL mul_15x17: got %h/%b want ff/0100", b8.out, b8.flags); end
      tick();
      checks++; if (b8.done !== 1'b0 || b8.busy !== 1'b0) begin errors++; $display("FAIL mul_start_ignored: got done=%b busy=%b want 0/0", b8.done, b8.busy); end
   endtask

   task automatic test_back_to_back();
      int lat;
      b8.start = 1'b1; b8.op = OP_MUL; b8.in1 = 8'd16; b8.in2 = 8'd16;
      tick();
      b8.start = 1'b0;
      lat = 1;
      while (b8.done !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      checks++; if (lat != 9 || b8.out !== 8'h00 || b8.flags !== 4'b1010) begin errors++; $display("FAIL mul_16x16: got lat=%0d %h/%b want 9 00/1010", lat, b8.out, b8.flags); end
      b8.start = 1'b1; b8.op = OP_ADD; b8.in1 = 8'h03; b8.in2 = 8'h04;
      tick();
      b8.start = 1'b0;
      checks++; if (b8.done !== 1'b1 || b8.out !== 8'h07 || b8.flags !== 4'b0000) begin errors++; $display("FAIL start_in_done_cycle: got done=%b %h/%b want 1 07/0000", b8.done, b8.out, b8.flags); end
      tick();
   endtask

   task automatic test_reset_mid_mul();
      int seen;
      b8.start = 1'b1; b8.op = OP_SUB; b8.in1 = 8'h10; b8.in2 = 8'h20;
      tick();
      b8.op = OP_MUL; b8.in1 = 8'd9; b8.in2 = 8'd7;
      tick();
      b8.start = 1'b0;
      tick(); tick(); tick();
      checks++; if (b8.busy !== 1'b1 || b8.out !== 8'hF0) begin errors++; $display("FAIL pre_reset_state: got busy=%b out=%h want 1/f0", b8.busy, b8.out); end
      #3;
      rst = 1'b1;
      #1;
      checks++; if (b8.busy !== 1'b0 || b8.done !== 1'b0 || b8.out !== 8'h00 || b8.flags !== 4'b0000) begin errors++; $display("FAIL async_reset_abort: got busy=%b done=%b %h/%b want 0 0 00/0000", b8.busy, b8.done, b8.out, b8.flags); end
      tick();
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 14; i++) begin
         if (b8.done === 1'b1 || b8.busy === 1'b1) seen++;
         tick();
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL no_done_after_abort: got %0d active cycles want 0", seen); end
   endtask

   task automatic test_width16();
      int lat;
      b16.start = 1'b1; b16.op = OP_ADD; b16.in1 = 16'h7FFF; b16.in2 = 16'h0001;
      tick();
      b16.start = 1'b0;
      checks++; if (b16.done !== 1'b1 || b16.out !== 16'h8000 || b16.flags !== 4'b0101) begin errors++; $display("FAIL w16_add: got done=%b %h/%b want 1 8000/0101", b16.done, b16.out, b16.flags); end
      tick();
      b16.start = 1'b1; b16.op = OP_MUL; b16.in1 = 16'h1234; b16.in2 = 16'h0003;
      tick();
      b16.start = 1'b0; b16.in1 = 16'hFFFF; b16.in2 = 16'hFFFF;
      lat = 1;
      while (b16.done !== 1'b1 && lat < 60) begin
         tick();
         lat++;
      end
      checks++; if (lat != 17) begin errors++; $display("FAIL w16_mul_latency: got %0d want 17", lat); end
      checks++; if (b16.out !== 16'h369C || b16.flags !== 4'b0000) begin errors++; $display("FAIL w16_mul: got %h/%b want 369c/0000", b16.out, b16.flags); end
      tick();
   endtask

   initial begin
      test_reset();
      test_add_sub();
      test_ops();
      test_mul_ignore();
      test_back_to_back();
      test_reset_mid_mul();
      test_width16();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised ALU replacing the combinational datapath ALU. Takes operands and an opcode under a START/DONE handshake, produces a registered result plus Z/N/C/V flags. Single-cycle ops complete in one clock; an iterative shift-add multiply runs over WIDTH clocks. It sits between the register file/immediate mux and the write-back stage; the controller stalls on BUSY.

## Interface
- WIDTH, 8, operand/result width in bits (legal range 4–32)
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- START  in  1  request; sampled only when BUSY=0
- OP  in  4  opcode, sampled with START
- IN1  in  WIDTH  operand A, sampled with START
- IN2  in  WIDTH  operand B, sampled with START
- BUSY  out  1  high while a multiply is iterating
- DONE  out  1  one-cycle pulse; OUT/FLAGS are valid from this cycle on
- OUT  out  WIDTH  registered result, held until next completion
- FLAGS  out  4  {Z,N,C,V}, registered, held with OUT

## Operation
- Opcodes: 0 ADD, 1 SUB (IN1−IN2), 2 PASS (IN1), 3 INC (IN1+1), 4 DEC2 (IN1−2), 5 DEC (IN1−1), 6 AND, 7 OR, 8 XOR, 9 SHL (IN1<<1), 10 SHR (IN1>>1, logical), 11 MUL (unsigned, low WIDTH bits), 12–15 illegal.
- Arithmetic is computed at WIDTH+1 bits; OUT takes the low WIDTH bits.
- Z = (OUT==0); N = OUT[WIDTH−1].
- C: ADD/INC carry-out; SUB/DEC/DEC2 borrow (1 when minuend < subtrahend, unsigned); SHL bit shifted out of MSB; SHR bit shifted out of LSB; MUL 1 when the upper WIDTH bits of the full product are nonzero; PASS/logic 0.
- V: signed two's-complement overflow for ADD/SUB/INC/DEC/DEC2; 0 for all other ops.
- Illegal opcode: OUT=0, FLAGS={1,0,0,0}, completes as a single-cycle op.
- FSM states: IDLE, MUL, with transitions as follows.
  - IDLE + START + single-cycle op: register result and flags, stay in IDLE, DONE=1 next cycle.
  - IDLE + START + MUL: latch operands, clear accumulator, set counter=WIDTH, go to MUL, BUSY=1.
  - MUL: each cycle, if multiplier LSB is 1, add multiplicand to the 2·WIDTH accumulator; shift multiplier right and multiplicand left; decrement counter. When the counter reaches 0, write OUT/FLAGS, return to IDLE, BUSY=0, DONE=1.
- START while BUSY=1 is ignored, not queued.
- START in the same cycle DONE is high (BUSY=0) is accepted, so back-to-back ops are allowed.
- OP/IN1/IN2 are don't-care except in the START sample cycle; mid-MUL operand changes have no effect.

## Timing
- Reset values: OUT=0, FLAGS=0, BUSY=0, DONE=0, state IDLE, counter 0, accumulator 0.
- RST is asynchronous; assertion mid-MUL aborts the operation immediately, with no DONE and OUT/FLAGS cleared.
- Single-cycle op: START sampled at edge t; OUT/FLAGS update and DONE=1 during cycle t+1. Latency is 1.
- MUL: START sampled at edge t; BUSY=1 during cycles t+1..t+WIDTH; OUT/FLAGS update and DONE=1 during cycle t+WIDTH+1, with BUSY=0 in that cycle. Latency is WIDTH+1.
- DONE is never high for two consecutive cycles unless a new START was accepted in between.
- No combinational path from inputs to outputs.

## Structure
- Shared package alu_pkg holds:
  - opcode localparams (OP_ADD..OP_MUL)
  - FSM state encoding (ST_IDLE, ST_MUL)
  - flag bit indices (FLG_Z=3, FLG_N=2, FLG_C=1, FLG_V=0)
- One sub-module, alu_mul_seq, contains the iterative shift-add multiplier: WIDTH parameter, start/busy/done, 2·WIDTH product output.
- The top level holds the single-cycle datapath, flag logic, and result/flag registers.

## Test plan
- WIDTH=8, ADD 8'hFF+8'h01 -> OUT=8'h00, FLAGS Z=1 N=0 C=1 V=0, DONE exactly one cycle after START.
- SUB 8'h80−8'h01 -> OUT=8'h7F, V=1, C=0. DEC2 on 8'h01 -> OUT=8'hFF, N=1, C=1, V=0.
- MUL 15×17 -> OUT=8'hFF, C=0, BUSY high 8 cycles, DONE at cycle 9. MUL 16×16 -> OUT=8'h00, Z=1, C=1.
- START pulsed with ADD during a MUL's BUSY window -> ignored; only the MUL result appears. START asserted in the DONE cycle -> accepted.
- RST asserted at MUL iteration 4 -> BUSY/DONE/OUT/FLAGS go to 0 without waiting for a clock edge, and no DONE follows. Opcode 4'hC -> OUT=0, FLAGS=4'b1000, DONE after 1 cycle.
- Regression at WIDTH=16: ADD 16'h7FFF+16'h0001 -> OUT=16'h8000, N=1, V=1; MUL latency 17.
